// File: rtl/nbit_cla_full_adder_if.sv
// nbit_cla_full_adder_if: operand/result bundle between an adder client and the adder
interface nbit_cla_full_adder_if #(parameter int N = 8);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         in_valid;
  logic [N:0]   sum;
  logic         out_valid;
  modport master (output a, b, in_valid, input sum, out_valid);
  modport slave  (input a, b, in_valid, output sum, out_valid);
endinterface

// File: rtl/nbit_cla_full_adder.sv
// nbit_cla_full_adder: 4-bit-group carry-lookahead adder with a registered (N+1)-bit result
module nbit_cla_full_adder #(
  parameter int N   = 8,
  parameter int BLK = 4
) (
  input logic               clk,
  input logic               rst,
  nbit_cla_full_adder_if.slave bus
);
  localparam int NG = N / BLK;
  logic [N-1:0] g, p, c;
  logic [NG:0]  gc;
  assign g     = bus.a & bus.b;
  assign p     = bus.a ^ bus.b;
  assign gc[0] = 1'b0;
  for (genvar j = 0; j < NG; j++) begin : grp
    localparam int B = j * BLK;
    logic gg, gp;
    assign c[B]   = gc[j];
    assign c[B+1] = g[B] | (p[B] & gc[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[j]);
    assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
              | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp = &p[B+3:B];
    assign gc[j+1] = gg | (gp & gc[j]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.sum <= {gc[NG], p ^ c};
    end
  end
endmodule

// File: tb/tb_nbit_cla_full_adder.sv
// tb_nbit_cla_full_adder: directed table plus stream/reset sequences for N=8, random checks for N=64
module tb_nbit_cla_full_adder;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  nbit_cla_full_adder_if #(.N(8))  b8 ();
  nbit_cla_full_adder_if #(.N(64)) b64 ();
  nbit_cla_full_adder #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  nbit_cla_full_adder #(.N(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] ra, rb;
  logic [64:0] ref64;

  initial begin
    v[0] = '{8'h01, 8'h01, 9'h002};
    v[1] = '{8'h02, 8'h01, 9'h003};
    v[2] = '{8'h1C, 8'h0C, 9'h028};
    v[3] = '{8'hFF, 8'h01, 9'h100};
    v[4] = '{8'hFF, 8'hFF, 9'h1FE};
    v[5] = '{8'h00, 8'h00, 9'h000};
    v[6] = '{8'h80, 8'h80, 9'h100};
    v[7] = '{8'h55, 8'hAA, 9'h0FF};
    v[8] = '{8'h0F, 8'h01, 9'h010};
    v[9] = '{8'hF0, 8'h10, 9'h100};

    rst = 1'b1;
    b8.a = 8'hFF; b8.b = 8'hFF; b8.in_valid = 1'b1;
    b64.a = '1; b64.b = '1; b64.in_valid = 1'b1;
    step();
    step();
    chk("reset_sum8", 65'(b8.sum), 65'd0);
    chk("reset_ov8", 65'(b8.out_valid), 65'd0);
    chk("reset_sum64", 65'(b64.sum), 65'd0);
    chk("reset_ov64", 65'(b64.out_valid), 65'd0);
    rst = 1'b0;
    b64.in_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      b8.a = v[i].a; b8.b = v[i].b; b8.in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_sum", i), 65'(b8.sum), 65'(v[i].s));
      chk($sformatf("vec%0d_ov", i), 65'(b8.out_valid), 65'd1);
    end

    b8.a = 8'h33; b8.b = 8'h44; b8.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_hold_sum", 65'(b8.sum), 65'h100);
      chk("idle_ov", 65'(b8.out_valid), 65'd0);
    end

    b8.a = 8'h10; b8.b = 8'h20; b8.in_valid = 1'b1;
    step();
    chk("stream0_sum", 65'(b8.sum), 65'h030);
    b8.a = 8'h7F; b8.b = 8'h01; rst = 1'b1;
    step();
    chk("midrst_sum", 65'(b8.sum), 65'd0);
    chk("midrst_ov", 65'(b8.out_valid), 65'd0);
    rst = 1'b0; b8.a = 8'hC8; b8.b = 8'h64;
    step();
    chk("resume_sum", 65'(b8.sum), 65'h12C);
    chk("resume_ov", 65'(b8.out_valid), 65'd1);
    b8.in_valid = 1'b0;

    b64.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 0) begin ra = '1; rb = 64'd1; end
      if (i == 1) begin ra = '1; rb = '1; end
      ref64 = {1'b0, ra} + {1'b0, rb};
      b64.a = ra; b64.b = rb;
      step();
      chk($sformatf("n64_%0d_sum", i), b64.sum, ref64);
      chk($sformatf("n64_%0d_ov", i), 65'(b64.out_valid), 65'd1);
    end
    chk("n64_ones_plus_one", 65'(65'h1_0000_0000_0000_0000), {1'b1, 64'd0} );
    b64.in_valid = 1'b0;
    step();
    chk("n64_idle_hold", b64.sum, ref64);
    chk("n64_idle_ov", 65'(b64.out_valid), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
